// File: rtl/platformnioscrc_nios2_gen2_0_cpu_debug_mem_if.sv
// CPU-side Avalon-MM slave port of the debug RAM (word addressed, waitrequest flow control).
// The master drives address/read/write/writedata and holds them until waitrequest drops.
interface platformnioscrc_nios2_gen2_0_cpu_debug_mem_if #(
  parameter int ADDR_W = 8
);
  logic [ADDR_W-1:0] cpu_address;
  logic              cpu_read;
  logic              cpu_write;
  logic [31:0]       cpu_writedata;
  logic [31:0]       cpu_readdata;
  logic              cpu_waitrequest;

  modport master (
    output cpu_address, cpu_read, cpu_write, cpu_writedata,
    input  cpu_readdata, cpu_waitrequest
  );

  modport slave (
    input  cpu_address, cpu_read, cpu_write, cpu_writedata,
    output cpu_readdata, cpu_waitrequest
  );
endinterface

// File: rtl/platformnioscrc_nios2_gen2_0_cpu_debug_mem.sv
// Debug RAM executing JTAG address/write/read-next commands; JTAG reads land in MonDReg 2 cycles after the strobe.
// CPU Avalon port (DEBUG_MEM_CPU_PORT_EN) is stalled while JTAG owns the RAM; strobes arriving when busy are dropped and flagged.
module platformnioscrc_nios2_gen2_0_cpu_debug_mem #(
  parameter int ADDR_W = 8
) (
  input  logic                                           clk,
  input  logic                                           reset,
  input  logic [37:0]                                    jdo,
  input  logic                                           take_action_ocimem_a,
  input  logic                                           take_action_ocimem_b,
  input  logic                                           take_no_action_ocimem_a,
  output logic [31:0]                                    MonDReg,
  output logic                                           monitor_ready,
  output logic                                           monitor_error,
  platformnioscrc_nios2_gen2_0_cpu_debug_mem_if.slave    cpu
);

  typedef enum logic [1:0] {IDLE, J_RD, C_RD} state_t;

  state_t            state;
  logic [ADDR_W-1:0] jaddr;
  logic [31:0]       mem [0:(1<<ADDR_W)-1];
  logic [31:0]       ram_q;

  logic              any_strobe;
  logic              cpu_rd_req;
  logic              cpu_wr_req;
  logic [ADDR_W-1:0] cpu_addr;
  logic [31:0]       cpu_wdata;

  logic              ram_we;
  logic              ram_re;
  logic [ADDR_W-1:0] ram_addr;
  logic [31:0]       ram_wdata;

  assign any_strobe = take_action_ocimem_a | take_action_ocimem_b | take_no_action_ocimem_a;

`ifdef DEBUG_MEM_CPU_PORT_EN
  logic [31:0] cpu_rd_hold;

  assign cpu_rd_req = cpu.cpu_read;
  assign cpu_wr_req = cpu.cpu_write;
  assign cpu_addr   = cpu.cpu_address;
  assign cpu_wdata  = cpu.cpu_writedata;

  // Read data is presented straight from the RAM register in C_RD, then held for the master.
  assign cpu.cpu_readdata = (state == C_RD) ? ram_q : cpu_rd_hold;

  always_comb begin
    cpu.cpu_waitrequest = cpu.cpu_read | cpu.cpu_write;
    if (state == C_RD) begin
      cpu.cpu_waitrequest = 1'b0;
    end else if (state == IDLE && !any_strobe && !reset && cpu.cpu_write) begin
      cpu.cpu_waitrequest = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cpu_rd_hold <= 32'h0;
    end else if (state == C_RD) begin
      cpu_rd_hold <= ram_q;
    end
  end
`else
  logic unused_cpu_inputs;

  assign cpu_rd_req          = 1'b0;
  assign cpu_wr_req          = 1'b0;
  assign cpu_addr            = '0;
  assign cpu_wdata           = 32'h0;
  assign cpu.cpu_readdata    = 32'h0;
  assign cpu.cpu_waitrequest = 1'b0;
  assign unused_cpu_inputs   = ^{cpu.cpu_address, cpu.cpu_read, cpu.cpu_write, cpu.cpu_writedata};
`endif

  logic unused_jdo_bits;
  assign unused_jdo_bits = ^{jdo[37:36], jdo[2:0]};

  // Single RAM port; JTAG strobes beat CPU requests, CPU write beats CPU read.
  always_comb begin
    ram_we    = 1'b0;
    ram_re    = 1'b0;
    ram_addr  = jaddr;
    ram_wdata = jdo[34:3];
    if (state == IDLE && !reset) begin
      if (take_action_ocimem_a) begin
        ram_addr = jdo[17 +: ADDR_W];
        ram_re   = jdo[34];
      end else if (take_action_ocimem_b) begin
        ram_we = 1'b1;
      end else if (take_no_action_ocimem_a) begin
        ram_re = 1'b1;
      end else if (cpu_wr_req) begin
        ram_we    = 1'b1;
        ram_addr  = cpu_addr;
        ram_wdata = cpu_wdata;
      end else if (cpu_rd_req) begin
        ram_re   = 1'b1;
        ram_addr = cpu_addr;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (ram_we) begin
      mem[ram_addr] <= ram_wdata;
    end
    if (ram_re) begin
      ram_q <= mem[ram_addr];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      jaddr         <= '0;
      MonDReg       <= 32'h0;
      monitor_ready <= 1'b1;
      monitor_error <= 1'b0;
    end else begin
      if (any_strobe && state != IDLE) begin
        monitor_error <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (take_action_ocimem_a) begin
            jaddr <= jdo[17 +: ADDR_W];
            if (jdo[35]) begin
              monitor_error <= 1'b0;
            end
            if (jdo[34]) begin
              monitor_ready <= 1'b0;
              state         <= J_RD;
            end
          end else if (take_action_ocimem_b) begin
            jaddr <= jaddr + 1'b1;
          end else if (take_no_action_ocimem_a) begin
            jaddr         <= jaddr + 1'b1;
            monitor_ready <= 1'b0;
            state         <= J_RD;
          end else if (cpu_rd_req && !cpu_wr_req) begin
            state <= C_RD;
          end
        end
        J_RD: begin
          MonDReg       <= ram_q;
          monitor_ready <= 1'b1;
          state         <= IDLE;
        end
        C_RD: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
